// File: rtl/fb_rect_compositor_if.sv
// Framebuffer write port driven by the rectangle compositor:
// pixel strobe, pixel colour and end-of-frame pulse.
interface fb_rect_compositor_if #(
  parameter int COLOR_BITS = 18
);
  logic                  fb_we;
  logic [COLOR_BITS-1:0] fb_data;
  logic                  fb_vsync;

  modport master (output fb_we, fb_data, fb_vsync);
  modport slave  (input  fb_we, fb_data, fb_vsync);
endinterface

// File: rtl/fb_rect_compositor.sv
// Raster pixel source: composites up to NUM_RECT prioritised filled rectangles
// over a background colour, with shadow slots applied atomically at frame start.
module fb_rect_compositor #(
  parameter  int WIDTH      = 640,
  parameter  int HEIGHT     = 480,
  parameter  int COLOR_BITS = 18,
  parameter  int PIXEL_DIV  = 4,
  parameter  int NUM_RECT   = 4,
  localparam int SEL_W      = $clog2(NUM_RECT),
  localparam int SLOT_W     = 41 + COLOR_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [COLOR_BITS-1:0]   bg_color,
  input  logic                    reg_we,
  input  logic [SEL_W-1:0]        reg_sel,
  input  logic [SLOT_W-1:0]       reg_wdata,
  input  logic                    commit,
  fb_rect_compositor_if.master    fb,
  output logic [15:0]             frame_cnt,
  output logic                    commit_pending
);

  localparam int DIV_W = $clog2(PIXEL_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, LATCH = 2'd1, SCAN = 2'd2, SYNC = 2'd3} state_t;

  // Slot layout: {en, color, y1, x1, y0, x0}; bounds are inclusive.
  function automatic logic slot_hit(input logic [SLOT_W-1:0] slot,
                                    input logic [9:0] px, input logic [9:0] py);
    return slot[SLOT_W-1] && (slot[9:0] <= px) && (px <= slot[29:20]) &&
           (slot[19:10] <= py) && (py <= slot[39:30]);
  endfunction

  state_t                state_r, next_state_s;
  logic [SLOT_W-1:0]     shadow_r [NUM_RECT];
  logic [SLOT_W-1:0]     active_r [NUM_RECT];
  logic [COLOR_BITS-1:0] bg_r;
  logic                  commit_pending_r;
  logic [9:0]            x_r, y_r;
  logic [DIV_W-1:0]      div_r;
  logic                  done_r;
  logic                  fb_we_r, fb_vsync_r;
  logic [COLOR_BITS-1:0] fb_data_r;
  logic [15:0]           frame_cnt_r;
  logic [9:0]            hx_s, hy_s;
  logic [COLOR_BITS-1:0] pix_s;
  logic [SLOT_W-1:0]     slot_s;
  logic                  last_s, emit_s, scan_end_s;

  // Pixel 0 is resolved during LATCH itself, so it sees the slots and background being latched.
  always_comb begin
    hx_s   = (state_r == LATCH) ? 10'd0 : x_r;
    hy_s   = (state_r == LATCH) ? 10'd0 : y_r;
    last_s = (hx_s == 10'(WIDTH - 1)) && (hy_s == 10'(HEIGHT - 1));
    pix_s  = (state_r == LATCH) ? bg_color : bg_r;
    slot_s = {SLOT_W{1'b0}};
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      slot_s = ((state_r == LATCH) && commit_pending_r) ? shadow_r[i] : active_r[i];
      pix_s  = slot_hit(slot_s, hx_s, hy_s) ? slot_s[SLOT_W-2:40] : pix_s;
    end
  end

  // Pixel issue and end-of-scan strobes.
  always_comb begin
    emit_s     = (state_r == LATCH) ||
                 ((state_r == SCAN) && !done_r && (div_r == DIV_W'(PIXEL_DIV - 1)));
    scan_end_s = (state_r == SCAN) && done_r && (div_r == DIV_W'(1));
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = enable ? LATCH : IDLE;
      LATCH:   next_state_s = SCAN;
      SCAN:    next_state_s = scan_end_s ? SYNC : SCAN;
      SYNC:    next_state_s = enable ? LATCH : IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Shadow/active slot banks, latched background and pending-commit flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        shadow_r[i] <= {SLOT_W{1'b0}};
        active_r[i] <= {SLOT_W{1'b0}};
      end
      bg_r             <= {COLOR_BITS{1'b0}};
      commit_pending_r <= 1'b0;
    end else begin
      if (state_r == LATCH) begin
        if (commit_pending_r) begin
          for (int i = 0; i < NUM_RECT; i++) active_r[i] <= shadow_r[i];
        end
        bg_r             <= bg_color;
        commit_pending_r <= commit;
      end else begin
        commit_pending_r <= commit_pending_r | commit;
      end
      if (reg_we) shadow_r[reg_sel] <= reg_wdata;
    end
  end

  // Raster position of the next pixel, clock divider and last-pixel-issued flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r    <= 10'd0;
      y_r    <= 10'd0;
      div_r  <= {DIV_W{1'b0}};
      done_r <= 1'b0;
    end else begin
      div_r  <= ((state_r == SCAN) && (div_r != DIV_W'(PIXEL_DIV - 1))) ?
                div_r + DIV_W'(1) : {DIV_W{1'b0}};
      done_r <= ((state_r == SCAN) && done_r) || (emit_s && last_s);
      if (emit_s) begin
        if (hx_s == 10'(WIDTH - 1)) begin
          x_r <= 10'd0;
          y_r <= (hy_s == 10'(HEIGHT - 1)) ? 10'd0 : hy_s + 10'd1;
        end else begin
          x_r <= hx_s + 10'd1;
          y_r <= hy_s;
        end
      end
    end
  end

  // Registered framebuffer port and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we_r     <= 1'b0;
      fb_data_r   <= {COLOR_BITS{1'b0}};
      fb_vsync_r  <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      fb_we_r    <= emit_s;
      fb_vsync_r <= scan_end_s;
      if (emit_s)     fb_data_r   <= pix_s;
      if (scan_end_s) frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end

  assign fb.fb_we        = fb_we_r;
  assign fb.fb_data      = fb_data_r;
  assign fb.fb_vsync     = fb_vsync_r;
  assign frame_cnt       = frame_cnt_r;
  assign commit_pending  = commit_pending_r;

endmodule

// File: tb/tb_fb_rect_compositor.sv
// Self-checking bench for fb_rect_compositor: directed scenarios plus random host
// traffic, compared every cycle against a frame-schedule reference model.
module tb_fb_rect_compositor;
  localparam int W = 8, H = 4, CB = 18, D = 4, NR = 4;
  localparam int N = W * H;
  localparam int PER = (N - 1) * D + 4;
  localparam logic [CB-1:0] GREEN = 18'h00FC0, RED = 18'h3F000, BLUE = 18'h0003F;

  logic            clk = 1'b0, rst = 1'b1, enable = 1'b0, reg_we = 1'b0, commit = 1'b0;
  logic [CB-1:0]   bg_color = '0;
  logic [1:0]      reg_sel = '0;
  logic [40+CB:0]  reg_wdata = '0;
  logic [15:0]     frame_cnt;
  logic            commit_pending;

  fb_rect_compositor_if #(.COLOR_BITS(CB)) fbi ();

  fb_rect_compositor #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB), .PIXEL_DIV(D), .NUM_RECT(NR)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bg_color(bg_color), .reg_we(reg_we),
    .reg_sel(reg_sel), .reg_wdata(reg_wdata), .commit(commit), .fb(fbi),
    .frame_cnt(frame_cnt), .commit_pending(commit_pending)
  );

  always #5 clk = ~clk;

  typedef struct { bit en; logic [CB-1:0] color; int x0, y0, x1, y1; } rect_t;

  // Reference model: slot banks, latched background, and the frame schedule
  rect_t         sh [NR];
  rect_t         ac [NR];
  logic [CB-1:0] bg_m;
  bit            busy, pend;
  int            lat, cyc, fcnt;
  int            n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic rect_t decode(input logic [40+CB:0] w);
    rect_t r;
    r.x0 = int'(w[9:0]);   r.y0 = int'(w[19:10]);
    r.x1 = int'(w[29:20]); r.y1 = int'(w[39:30]);
    r.color = w[40 +: CB]; r.en = w[40+CB];
    return r;
  endfunction

  function automatic logic [CB-1:0] ref_pix(input int x, input int y);
    for (int i = 0; i < NR; i++)
      if (ac[i].en && ac[i].x0 <= x && x <= ac[i].x1 && ac[i].y0 <= y && y <= ac[i].y1)
        return ac[i].color;
    return bg_m;
  endfunction

  // Check this cycle's outputs, fold this cycle's inputs into the model, advance one clock
  task automatic step();
    bit e_we, e_vs;
    logic [CB-1:0] e_data;
    int off;
    e_we = 1'b0; e_vs = 1'b0; e_data = '0;
    if (busy && cyc > lat) begin
      off = cyc - lat - 1;
      if (off % D == 0 && off / D < N) begin
        e_we = 1'b1;
        e_data = ref_pix((off / D) % W, (off / D) / W);
      end
      if (cyc == lat + PER - 1) begin
        e_vs = 1'b1;
        fcnt++;
      end
    end
    check_eq("fb_we", 32'(fbi.fb_we), 32'(e_we));
    check_eq("fb_vsync", 32'(fbi.fb_vsync), 32'(e_vs));
    if (e_we) check_eq("fb_data", 32'(fbi.fb_data), 32'(e_data));
    check_eq("frame_cnt", 32'(frame_cnt), 32'(fcnt[15:0]));
    check_eq("commit_pending", 32'(commit_pending), 32'(pend));

    if (busy && cyc == lat) begin
      if (pend) ac = sh;
      bg_m = bg_color;
      pend = commit;
    end else if (commit) begin
      pend = 1'b1;
    end
    if (reg_we) sh[reg_sel] = decode(reg_wdata);
    if (!busy) begin
      if (enable) begin busy = 1'b1; lat = cyc + 1; end
    end else if (cyc == lat + PER - 1) begin
      if (enable) lat = cyc + 1;
      else        busy = 1'b0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_latch();
    int n = 0;
    while (!(busy && cyc == lat) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check_eq("latch_wait", 32'(busy && cyc == lat), 32'd1);
  endtask

  task automatic put_slot(input int sel, input bit en, input logic [CB-1:0] col,
                          input logic [9:0] x0, input logic [9:0] y0,
                          input logic [9:0] x1, input logic [9:0] y1, input bit cm);
    reg_we = 1'b1; reg_sel = sel[1:0]; reg_wdata = {en, col, y1, x1, y0, x0}; commit = cm;
    step();
    reg_we = 1'b0; commit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_fb_we", 32'(fbi.fb_we), 32'd0);
    check_eq("rst_fb_data", 32'(fbi.fb_data), 32'd0);
    check_eq("rst_fb_vsync", 32'(fbi.fb_vsync), 32'd0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("rst_commit_pending", 32'(commit_pending), 32'd0);
    busy = 1'b0; pend = 1'b0; fcnt = 0; cyc = 0; lat = 0; bg_m = '0;
    for (int i = 0; i < NR; i++) begin
      sh[i] = '{default: 0};
      ac[i] = '{default: 0};
    end
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Background-only first frame
    bg_color = 18'h3F03F;
    enable = 1'b1;
    run(PER + 2);
    check_eq("first_frame_cnt", 32'(frame_cnt), 32'd1);

    // Mid-frame slot write + commit: only the following frame changes
    run(40);
    put_slot(0, 1'b1, GREEN, 10'd2, 10'd1, 10'd4, 10'd2, 1'b1);
    run(2 * PER);

    // Priority overlap and an inverted slot that must never hit
    put_slot(1, 1'b1, RED, 10'd0, 10'd0, 10'd7, 10'd3, 1'b0);
    put_slot(2, 1'b1, BLUE, 10'd5, 10'd0, 10'd3, 10'd3, 1'b1);
    run(2 * PER);

    // Write without commit, then a commit landing exactly on LATCH
    run(30);
    put_slot(0, 1'b1, 18'h15555, 10'd0, 10'd0, 10'd7, 10'd3, 1'b0);
    run(2 * PER);
    wait_latch();
    commit = 1'b1;
    step();
    commit = 1'b0;
    run(2 * PER + 10);

    // Random host traffic, background changes and enable toggles
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reg_we = 1'b1;
        reg_sel = 2'($urandom_range(0, 3));
        reg_wdata = {($urandom_range(0, 3) != 0), 18'($urandom),
                     10'($urandom_range(0, 5)), 10'($urandom_range(0, 9)),
                     10'($urandom_range(0, 5)), 10'($urandom_range(0, 9))};
      end
      if ($urandom_range(0, 99) == 0) commit = 1'b1;
      if ($urandom_range(0, 149) == 0) bg_color = 18'($urandom);
      if ($urandom_range(0, 599) == 0) enable = ~enable;
      step();
      reg_we = 1'b0;
      commit = 1'b0;
    end

    // Enable dropped at pixel 10: frame completes, then idle
    enable = 1'b1;
    wait_latch();
    run(41);
    enable = 1'b0;
    run(PER + 50);

    // Reset in the middle of a scan; slots come back cleared
    enable = 1'b1;
    wait_latch();
    run(60);
    do_reset();
    run(PER + 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
